// File: rtl/tlb_rqst_arbiter_if.sv
// ---------------------------------------------------------------------------
// tlb_rqst_arbiter_if
// Bundles every signal between the two translation requesters, the shared
// speculative TLB and the tlb_rqst_arbiter.
//   Requester side : REQ_x, VADDR_x, SPEC_x in; DONE_x, PADDR_x, HIT_x out
//   TLB side       : TRANS_RQST, SPEC_TLB_RQST, VIRT_ADDR_LOOKUP out;
//                    DONE_TRANS, PHY_ADDR_TRANS, TLB_HIT in
//   Statistics     : LOOKUPS_x, HITS_x out
// Modports: slave = the arbiter, master = the environment (requesters + TLB).
// ---------------------------------------------------------------------------
interface tlb_rqst_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 8
);
   logic              REQ_A;
   logic              REQ_B;
   logic [ADDR_W-1:0] VADDR_A;
   logic [ADDR_W-1:0] VADDR_B;
   logic              SPEC_A;
   logic              SPEC_B;
   logic              DONE_A;
   logic              DONE_B;
   logic [ADDR_W-1:0] PADDR_A;
   logic [ADDR_W-1:0] PADDR_B;
   logic              HIT_A;
   logic              HIT_B;
   logic              TRANS_RQST;
   logic              SPEC_TLB_RQST;
   logic [ADDR_W-1:0] VIRT_ADDR_LOOKUP;
   logic              DONE_TRANS;
   logic [ADDR_W-1:0] PHY_ADDR_TRANS;
   logic              TLB_HIT;
   logic [CNT_W-1:0]  LOOKUPS_A;
   logic [CNT_W-1:0]  HITS_A;
   logic [CNT_W-1:0]  LOOKUPS_B;
   logic [CNT_W-1:0]  HITS_B;

   modport slave (
      input  REQ_A, REQ_B, VADDR_A, VADDR_B, SPEC_A, SPEC_B,
      input  DONE_TRANS, PHY_ADDR_TRANS, TLB_HIT,
      output DONE_A, DONE_B, PADDR_A, PADDR_B, HIT_A, HIT_B,
      output TRANS_RQST, SPEC_TLB_RQST, VIRT_ADDR_LOOKUP,
      output LOOKUPS_A, HITS_A, LOOKUPS_B, HITS_B
   );

   modport master (
      output REQ_A, REQ_B, VADDR_A, VADDR_B, SPEC_A, SPEC_B,
      output DONE_TRANS, PHY_ADDR_TRANS, TLB_HIT,
      input  DONE_A, DONE_B, PADDR_A, PADDR_B, HIT_A, HIT_B,
      input  TRANS_RQST, SPEC_TLB_RQST, VIRT_ADDR_LOOKUP,
      input  LOOKUPS_A, HITS_A, LOOKUPS_B, HITS_B
   );
endinterface

// File: rtl/tlb_rqst_arbiter.sv
// ---------------------------------------------------------------------------
// tlb_rqst_arbiter
// Shares one speculative TLB between two requesters (A = fetch, B = data).
// A request is granted round-robin, issued to the TLB as a one-cycle
// TRANS_RQST pulse, and the result returned to the winner with a one-cycle
// DONE_x pulse.
// Ports:
//   clk - single clock, all logic on posedge
//   rst - synchronous active-high reset
//   bus - tlb_rqst_arbiter_if.slave (requester, TLB and statistics signals)
// Optional feature: define TLB_ARB_STATS_EN to build saturating per-port
// lookup/hit counters; otherwise the counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module tlb_rqst_arbiter #(
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 8
) (
   input logic               clk,
   input logic               rst,
   tlb_rqst_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   state_t            state;
   logic              gnt;
   logic              last_gnt;
   logic              done_q;
   logic              trans_rqst;
   logic              spec_rqst;
   logic [ADDR_W-1:0] virt_addr;
   logic              done_a;
   logic              done_b;
   logic [ADDR_W-1:0] paddr_a;
   logic [ADDR_W-1:0] paddr_b;
   logic              hit_a;
   logic              hit_b;
   logic              pick;
   logic              done_rise;

   // Only a fresh rising edge counts, so a completion left high from an
   // earlier lookup cannot finish the current one.
   assign done_rise = bus.DONE_TRANS & ~done_q;

   // Arbitration: a lone requester wins; on a tie the port not served last wins.
   always_comb begin
      pick = PORT_A;
      if (bus.REQ_A && bus.REQ_B) begin
         pick = (last_gnt == PORT_B) ? PORT_A : PORT_B;
      end else if (bus.REQ_B) begin
         pick = PORT_B;
      end else begin
         pick = PORT_A;
      end
   end

   // Main FSM: grant, issue, wait for completion, respond.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         gnt        <= PORT_A;
         last_gnt   <= PORT_B;
         done_q     <= 1'b0;
         trans_rqst <= 1'b0;
         spec_rqst  <= 1'b0;
         virt_addr  <= {ADDR_W{1'b0}};
         done_a     <= 1'b0;
         done_b     <= 1'b0;
         paddr_a    <= {ADDR_W{1'b0}};
         paddr_b    <= {ADDR_W{1'b0}};
         hit_a      <= 1'b0;
         hit_b      <= 1'b0;
      end else begin
         done_q <= bus.DONE_TRANS;
         case (state)
            IDLE: begin
               done_a <= 1'b0;
               done_b <= 1'b0;
               if (bus.REQ_A || bus.REQ_B) begin
                  gnt        <= pick;
                  virt_addr  <= (pick == PORT_B) ? bus.VADDR_B : bus.VADDR_A;
                  spec_rqst  <= (pick == PORT_B) ? bus.SPEC_B  : bus.SPEC_A;
                  trans_rqst <= 1'b1;
                  state      <= ISSUE;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               trans_rqst <= 1'b0;
               spec_rqst  <= 1'b0;
               state      <= WAIT;
            end
            WAIT: begin
               if (done_rise) begin
                  if (gnt == PORT_A) begin
                     paddr_a <= bus.PHY_ADDR_TRANS;
                     hit_a   <= bus.TLB_HIT;
                     done_a  <= 1'b1;
                  end else begin
                     paddr_b <= bus.PHY_ADDR_TRANS;
                     hit_b   <= bus.TLB_HIT;
                     done_b  <= 1'b1;
                  end
                  state <= RESP;
               end else begin
                  state <= WAIT;
               end
            end
            RESP: begin
               done_a   <= 1'b0;
               done_b   <= 1'b0;
               last_gnt <= gnt;
               state    <= IDLE;
            end
            default: begin
               trans_rqst <= 1'b0;
               spec_rqst  <= 1'b0;
               done_a     <= 1'b0;
               done_b     <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign bus.TRANS_RQST       = trans_rqst;
   assign bus.SPEC_TLB_RQST    = spec_rqst;
   assign bus.VIRT_ADDR_LOOKUP = virt_addr;
   assign bus.DONE_A           = done_a;
   assign bus.DONE_B           = done_b;
   assign bus.PADDR_A          = paddr_a;
   assign bus.PADDR_B          = paddr_b;
   assign bus.HIT_A            = hit_a;
   assign bus.HIT_B            = hit_b;

`ifdef TLB_ARB_STATS_EN
   logic [CNT_W-1:0] lookups_a;
   logic [CNT_W-1:0] hits_a;
   logic [CNT_W-1:0] lookups_b;
   logic [CNT_W-1:0] hits_b;

   // Saturating increment: an all-ones counter stays put.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Statistics: count in RESP, when the captured hit flag is already stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         lookups_a <= {CNT_W{1'b0}};
         hits_a    <= {CNT_W{1'b0}};
         lookups_b <= {CNT_W{1'b0}};
         hits_b    <= {CNT_W{1'b0}};
      end else if (state == RESP) begin
         if (gnt == PORT_A) begin
            lookups_a <= sat_inc(lookups_a);
            if (hit_a) begin
               hits_a <= sat_inc(hits_a);
            end
         end else begin
            lookups_b <= sat_inc(lookups_b);
            if (hit_b) begin
               hits_b <= sat_inc(hits_b);
            end
         end
      end
   end

   assign bus.LOOKUPS_A = lookups_a;
   assign bus.HITS_A    = hits_a;
   assign bus.LOOKUPS_B = lookups_b;
   assign bus.HITS_B    = hits_b;
`else
   assign bus.LOOKUPS_A = {CNT_W{1'b0}};
   assign bus.HITS_A    = {CNT_W{1'b0}};
   assign bus.LOOKUPS_B = {CNT_W{1'b0}};
   assign bus.HITS_B    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_tlb_rqst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tlb_rqst_arbiter
// Self-checking bench for tlb_rqst_arbiter. A small TLB model answers each
// TRANS_RQST with PHY = VADDR ^ 0x100 and HIT = VADDR[0] (or a forced value),
// a scoreboard holds the expected issues and completions, and all driving
// and checking runs from one process at the falling clock edge.
// ---------------------------------------------------------------------------
module tb_tlb_rqst_arbiter;
   localparam int ADDR_W = 9;
   localparam int CNT_W  = 8;

   logic clk;
   logic rst;

   tlb_rqst_arbiter_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) ifc ();

   tlb_rqst_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic             port;
      logic [ADDR_W-1:0] paddr;
      logic             hit;
   } exp_t;

   typedef struct packed {
      logic [ADDR_W-1:0] va;
      logic              spec;
   } iss_t;

   typedef struct {
      logic              ra;
      logic              rb;
      logic [ADDR_W-1:0] va;
      logic [ADDR_W-1:0] vb;
      logic              sa;
      logic              sb;
      logic              ep;
      logic [ADDR_W-1:0] epa;
      logic              eh;
   } vec_t;

   exp_t exp_q[$];
   iss_t iss_q[$];
   vec_t vecs[8];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cd = 0;
   int lat = 2;
   int trans_cnt = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int ml_a = 0, mh_a = 0, ml_b = 0, mh_b = 0;
   bit tlb_auto = 1'b1;
   bit man_done = 1'b0;
   bit gap_mode = 1'b0;
   bit gap_arm = 1'b0;
   bit done_seen = 1'b0;
   bit hit_ovr_en = 1'b0;
   bit hit_ovr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic port, input logic [ADDR_W-1:0] va, input logic spec,
                       input logic [ADDR_W-1:0] epa, input logic eh);
      iss_t s;
      exp_t e;
      s.va = va;  s.spec = spec;
      e.port = port;  e.paddr = epa;  e.hit = eh;
      iss_q.push_back(s);
      exp_q.push_back(e);
   endtask

   // One clock cycle: TLB model, issue checks and completion scoreboard.
   task automatic tick();
      iss_t s;
      exp_t e;
      logic dt;
      @(negedge clk);
      cyc++;
      dt = 1'b0;
      if (ifc.SPEC_TLB_RQST && !ifc.TRANS_RQST) begin
         checks++; errors++;
         $display("FAIL spec_without_rqst: actual=1 required=0 at cycle %0d", cyc);
      end
      if (ifc.TRANS_RQST) begin
         trans_cnt++;
         if (iss_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue: actual vaddr=0x%0h required no request", ifc.VIRT_ADDR_LOOKUP);
         end else begin
            s = iss_q.pop_front();
            chk("issue_vaddr", ifc.VIRT_ADDR_LOOKUP, s.va);
            chk("issue_spec", ifc.SPEC_TLB_RQST, s.spec);
         end
         if (gap_arm) begin
            chk("issue_gap", cyc - last_done_cyc, 2);
            gap_arm = 1'b0;
         end
         ifc.PHY_ADDR_TRANS = ifc.VIRT_ADDR_LOOKUP ^ 9'h100;
         ifc.TLB_HIT = hit_ovr_en ? hit_ovr : ifc.VIRT_ADDR_LOOKUP[0];
         if (tlb_auto) cd = lat;
      end else if (cd > 0) begin
         cd--;
         if (cd == 0) dt = 1'b1;
      end
      ifc.DONE_TRANS = dt | man_done;
      if (ifc.DONE_A && ifc.DONE_B) begin
         checks++; errors++;
         $display("FAIL both_done: actual DONE_A=1 DONE_B=1 required one");
      end
      if (ifc.DONE_A || ifc.DONE_B) begin
         done_seen = 1'b1;
         done_cnt++;
         last_done_cyc = cyc;
         if (gap_mode) gap_arm = 1'b1;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: actual DONE_A=%0b DONE_B=%0b required none", ifc.DONE_A, ifc.DONE_B);
         end else begin
            e = exp_q.pop_front();
            chk("done_port", ifc.DONE_B, e.port);
            chk("done_paddr", ifc.DONE_B ? ifc.PADDR_B : ifc.PADDR_A, e.paddr);
            chk("done_hit", ifc.DONE_B ? ifc.HIT_B : ifc.HIT_A, e.hit);
            if (e.port) begin
               if (ml_b < 255) ml_b++;
               if (e.hit && mh_b < 255) mh_b++;
            end else begin
               if (ml_a < 255) ml_a++;
               if (e.hit && mh_a < 255) mh_a++;
            end
         end
      end
   endtask

   task automatic wait_done(input int budget);
      done_seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done_seen) break;
      end
      chk("done_timeout", done_seen, 1'b1);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      ml_a = 0; mh_a = 0; ml_b = 0; mh_b = 0;
      exp_q.delete();
      iss_q.delete();
      cd = 0;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   task automatic check_counters();
`ifdef TLB_ARB_STATS_EN
      chk("lookups_a", ifc.LOOKUPS_A, ml_a);
      chk("hits_a", ifc.HITS_A, mh_a);
      chk("lookups_b", ifc.LOOKUPS_B, ml_b);
      chk("hits_b", ifc.HITS_B, mh_b);
`else
      chk("lookups_a_off", ifc.LOOKUPS_A, 0);
      chk("hits_a_off", ifc.HITS_A, 0);
      chk("lookups_b_off", ifc.LOOKUPS_B, 0);
      chk("hits_b_off", ifc.HITS_B, 0);
`endif
   endtask

   task automatic check_reset_outputs();
      chk("rst_done_a", ifc.DONE_A, 0);
      chk("rst_done_b", ifc.DONE_B, 0);
      chk("rst_hit_a", ifc.HIT_A, 0);
      chk("rst_hit_b", ifc.HIT_B, 0);
      chk("rst_paddr_a", ifc.PADDR_A, 0);
      chk("rst_paddr_b", ifc.PADDR_B, 0);
      chk("rst_trans_rqst", ifc.TRANS_RQST, 0);
      chk("rst_spec_rqst", ifc.SPEC_TLB_RQST, 0);
      chk("rst_virt_addr", ifc.VIRT_ADDR_LOOKUP, 0);
      chk("rst_lookups_a", ifc.LOOKUPS_A, 0);
      chk("rst_hits_a", ifc.HITS_A, 0);
      chk("rst_lookups_b", ifc.LOOKUPS_B, 0);
      chk("rst_hits_b", ifc.HITS_B, 0);
   endtask

   initial begin
      int d0;
      int t0;
      logic [ADDR_W-1:0] va;

      // ra rb  va      vb      sa sb  ep  epa     eh
      vecs[0] = '{1'b1, 1'b0, 9'h05A, 9'h000, 1'b1, 1'b0, 1'b0, 9'h15A, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 9'h000, 9'h0F1, 1'b0, 1'b0, 1'b1, 9'h1F1, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 9'h011, 9'h022, 1'b0, 1'b1, 1'b0, 9'h111, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 9'h033, 9'h044, 1'b1, 1'b0, 1'b1, 9'h144, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 9'h1FF, 9'h000, 1'b0, 1'b0, 1'b0, 9'h0FF, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 9'h000, 9'h100, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 9'h0A5, 9'h000, 1'b1, 1'b0, 1'b0, 9'h1A5, 1'b1};
      vecs[7] = '{1'b1, 1'b1, 9'h002, 9'h003, 1'b1, 1'b1, 1'b1, 9'h103, 1'b1};

      rst = 1'b1;
      ifc.REQ_A = 1'b0;  ifc.REQ_B = 1'b0;
      ifc.VADDR_A = 9'h000;  ifc.VADDR_B = 9'h000;
      ifc.SPEC_A = 1'b0;  ifc.SPEC_B = 1'b0;
      ifc.DONE_TRANS = 1'b0;  ifc.PHY_ADDR_TRANS = 9'h000;  ifc.TLB_HIT = 1'b0;

      do_reset(3);
      tick();
      check_reset_outputs();

      // Tie from reset: A, B, A, B with each port's own address.
      ifc.VADDR_A = 9'h011;  ifc.SPEC_A = 1'b1;
      ifc.VADDR_B = 9'h022;  ifc.SPEC_B = 1'b0;
      ifc.REQ_A = 1'b1;  ifc.REQ_B = 1'b1;
      push(1'b0, 9'h011, 1'b1, 9'h111, 1'b1);
      push(1'b1, 9'h022, 1'b0, 9'h122, 1'b0);
      push(1'b0, 9'h033, 1'b0, 9'h133, 1'b1);
      push(1'b1, 9'h044, 1'b1, 9'h144, 1'b0);
      for (int i = 0; i < 4; i++) begin
         wait_done(60);
         if (i == 0) begin ifc.VADDR_A = 9'h033; ifc.SPEC_A = 1'b0; end
         if (i == 1) begin ifc.VADDR_B = 9'h044; ifc.SPEC_B = 1'b1; end
         if (i == 3) begin ifc.REQ_A = 1'b0; ifc.REQ_B = 1'b0; end
      end
      repeat (2) tick();

      // Table of single transactions with varying TLB latency.
      for (int i = 0; i < 8; i++) begin
         lat = 1 + (i % 3);
         ifc.VADDR_A = vecs[i].va;  ifc.SPEC_A = vecs[i].sa;
         ifc.VADDR_B = vecs[i].vb;  ifc.SPEC_B = vecs[i].sb;
         ifc.REQ_A = vecs[i].ra;  ifc.REQ_B = vecs[i].rb;
         push(vecs[i].ep, vecs[i].ep ? vecs[i].vb : vecs[i].va,
              vecs[i].ep ? vecs[i].sb : vecs[i].sa, vecs[i].epa, vecs[i].eh);
         wait_done(60);
         ifc.REQ_A = 1'b0;  ifc.REQ_B = 1'b0;
         tick();
      end
      check_counters();

      // Continuous requesting on B: each new issue 2 cycles after DONE_B.
      lat = 2;
      gap_mode = 1'b1;
      t0 = trans_cnt;
      ifc.VADDR_B = 9'h0B0;  ifc.SPEC_B = 1'b0;  ifc.REQ_B = 1'b1;
      push(1'b1, 9'h0B0, 1'b0, 9'h1B0, 1'b0);
      push(1'b1, 9'h0B1, 1'b1, 9'h1B1, 1'b1);
      push(1'b1, 9'h0B2, 1'b0, 9'h1B2, 1'b0);
      for (int j = 0; j < 3; j++) begin
         wait_done(60);
         if (j == 0) begin ifc.VADDR_B = 9'h0B1; ifc.SPEC_B = 1'b1; end
         if (j == 1) begin ifc.VADDR_B = 9'h0B2; ifc.SPEC_B = 1'b0; end
         if (j == 2) ifc.REQ_B = 1'b0;
      end
      gap_mode = 1'b0;
      gap_arm = 1'b0;
      repeat (4) tick();
      chk("continuous_issue_count", trans_cnt - t0, 3);

      // Stale completion: DONE_TRANS already high entering WAIT.
      tlb_auto = 1'b0;
      ifc.VADDR_A = 9'h0C3;  ifc.SPEC_A = 1'b0;  ifc.REQ_A = 1'b1;
      man_done = 1'b1;
      push(1'b0, 9'h0C3, 1'b0, 9'h1C3, 1'b1);
      d0 = done_cnt;
      repeat (6) tick();
      chk("stale_ignored", done_cnt, d0);
      man_done = 1'b0;
      tick();
      man_done = 1'b1;
      wait_done(20);
      man_done = 1'b0;
      ifc.REQ_A = 1'b0;
      repeat (3) tick();
      chk("stale_one_done", done_cnt, d0 + 1);

      // Reset in WAIT, then a late completion.
      ifc.VADDR_A = 9'h066;  ifc.SPEC_A = 1'b1;  ifc.REQ_A = 1'b1;
      push(1'b0, 9'h066, 1'b1, 9'h166, 1'b0);
      repeat (2) tick();
      ifc.REQ_A = 1'b0;
      do_reset(1);
      d0 = done_cnt;
      man_done = 1'b1;
      repeat (2) tick();
      man_done = 1'b0;
      repeat (3) tick();
      chk("reset_no_done", done_cnt, d0);
      check_reset_outputs();
      tlb_auto = 1'b1;

      // Statistics saturation: 300 lookups on A, first 260 hit.
      do_reset(2);
      tick();
      lat = 1;
      hit_ovr_en = 1'b1;
      va = 9'h000;
      ifc.REQ_A = 1'b1;
      ifc.SPEC_A = 1'b0;
      for (int i = 0; i < 300; i++) begin
         hit_ovr = (i < 260);
         ifc.VADDR_A = va;
         push(1'b0, va, 1'b0, va ^ 9'h100, hit_ovr);
         wait_done(40);
         va = va + 9'h001;
      end
      ifc.REQ_A = 1'b0;
      hit_ovr_en = 1'b0;
      repeat (3) tick();
`ifdef TLB_ARB_STATS_EN
      chk("sat_lookups_a", ifc.LOOKUPS_A, 255);
      chk("sat_hits_a", ifc.HITS_A, 255);
      chk("sat_lookups_b", ifc.LOOKUPS_B, 0);
      chk("sat_hits_b", ifc.HITS_B, 0);
`else
      check_counters();
`endif
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
